// File: rtl/vga_timing_gen.sv
// 640x480@60 VGA timing back-end: divide-by-2 pixel enable, coordinate request
// one tick ahead of display, and a registered RGB/sync/blank output stage.
module vga_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic [7:0] pix_r,
  input  logic [7:0] pix_g,
  input  logic [7:0] pix_b,
  output logic [9:0] pixel_x,
  output logic [9:0] pixel_y,
  output logic       pixel_req,
  output logic       frame_start,
  output logic       VGA_CLK,
  output logic       VGA_HS,
  output logic       VGA_VS,
  output logic       VGA_BLANK_N,
  output logic       VGA_SYNC_N,
  output logic [7:0] VGA_R,
  output logic [7:0] VGA_G,
  output logic [7:0] VGA_B
);

  localparam logic [9:0] H_ACT        = 10'(H_ACTIVE);
  localparam logic [9:0] H_SYNC_START = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] H_SYNC_END   = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] H_TOT        = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP);
  localparam logic [9:0] V_ACT        = 10'(V_ACTIVE);
  localparam logic [9:0] V_SYNC_START = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] V_SYNC_END   = 10'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [9:0] V_TOT        = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP);

  logic       ce;
  logic       pixelTick;
  logic [9:0] hCnt;
  logic [9:0] vCnt;
  logic       hTerm;
  logic       vTerm;
  logic       activeNow;
  logic       hsNow;
  logic       vsNow;
  logic       hs1;
  logic       vs1;

  // NOTE: every clocked block uses non-blocking assignments so all registers
  // sample pre-edge values; blocking here would race between the stages.
  always_ff @(posedge CLOCK_50) begin
    if (reset) ce <= 1'b0;
    else       ce <= ~ce;
  end

  // The DAC sees its rising edge on the tick, so data changes on its falling edge.
  assign pixelTick  = ce;
  assign VGA_CLK    = ce;
  assign VGA_SYNC_N = 1'b0;

  // NOTE: every combinational output is assigned first thing, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    hTerm     = (hCnt == H_TOT - 10'd1);
    vTerm     = (vCnt == V_TOT - 10'd1);
    activeNow = (hCnt < H_ACT) && (vCnt < V_ACT);
    hsNow     = !((hCnt >= H_SYNC_START) && (hCnt < H_SYNC_END));
    vsNow     = !((vCnt >= V_SYNC_START) && (vCnt < V_SYNC_END));
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      hCnt <= '0;
      vCnt <= '0;
    end else if (pixelTick) begin
      if (hTerm) begin
        hCnt <= '0;
        vCnt <= vTerm ? 10'd0 : vCnt + 10'd1;
      end else begin
        hCnt <= hCnt + 10'd1;
      end
    end
  end

  // Stage 1: coordinate request to the colour source, plus delayed sync decode.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      pixel_x   <= '0;
      pixel_y   <= '0;
      pixel_req <= 1'b0;
      hs1       <= 1'b1;
      vs1       <= 1'b1;
    end else if (pixelTick) begin
      pixel_x   <= hCnt;
      pixel_y   <= vCnt;
      pixel_req <= activeNow;
      hs1       <= hsNow;
      vs1       <= vsNow;
    end
  end

  // Stage 2: colour returns one tick after the request, aligned with sync/blank.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      VGA_HS      <= 1'b1;
      VGA_VS      <= 1'b1;
      VGA_BLANK_N <= 1'b0;
      VGA_R       <= '0;
      VGA_G       <= '0;
      VGA_B       <= '0;
    end else if (pixelTick) begin
      VGA_HS      <= hs1;
      VGA_VS      <= vs1;
      VGA_BLANK_N <= pixel_req;
      VGA_R       <= pixel_req ? pix_r : 8'd0;
      VGA_G       <= pixel_req ? pix_g : 8'd0;
      VGA_B       <= pixel_req ? pix_b : 8'd0;
    end
  end

  // Frame start marks the tick that loads (0,0) into stage 1.
  assign frame_start = pixelTick && (hCnt == 10'd0) && (vCnt == 10'd0);

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Display back-end for the Project1 top level. Sits downstream of the pixel/colour source and drives the board VGA DAC pins.
- Generates 640x480@60 timing from CLOCK_50 using a divide-by-2 pixel enable.
- Issues pixel coordinates to the upstream colour source one pixel tick ahead of display.
- Registers the returned RGB so that colour, sync and blank leave the block aligned.

Parameters:
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch (pixels)
H_SYNC, 96, horizontal sync width (pixels)
H_BP, 48, horizontal back porch (pixels)
V_ACTIVE, 480, visible lines per frame
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vertical sync width (lines)
V_BP, 33, vertical back porch (lines)

Ports:
CLOCK_50  in  1  system clock, 50 MHz; sole clock
reset  in  1  synchronous, active-high reset
pix_r  in  8  upstream red for the requested pixel
pix_g  in  8  upstream green
pix_b  in  8  upstream blue
pixel_x  out  10  requested column (0..H_ACTIVE-1 when pixel_req=1)
pixel_y  out  10  requested row (0..V_ACTIVE-1 when pixel_req=1)
pixel_req  out  1  pixel_x/pixel_y are inside the active area
frame_start  out  1  one-CLOCK_50-cycle pulse at the start of each frame
VGA_CLK  out  1  25 MHz pixel clock to DAC
VGA_HS  out  1  horizontal sync, active low
VGA_VS  out  1  vertical sync, active low
VGA_BLANK_N  out  1  low outside active area
VGA_SYNC_N  out  1  tied 0 (no sync-on-green)
VGA_R  out  8  red to DAC
VGA_G  out  8  green to DAC
VGA_B  out  8  blue to DAC

Behaviour:
- Width rules: H_TOT = H_ACTIVE+H_FP+H_SYNC+H_BP (800); V_TOT = V_ACTIVE+V_FP+V_SYNC+V_BP (525). Both counters are 10 bits, with all arithmetic unsigned.
- Pixel enable: `ce` toggles every CLOCK_50 cycle; a pixel tick is a cycle where ce=1. VGA_CLK is a register equal to ce, so ticks fall on VGA_CLK rising edges seen by the DAC (falling edge at ce=0 → data stable). All state below updates only on ticks, except ce itself.
- Counters: h_cnt increments each tick and wraps H_TOT-1→0. v_cnt increments when h_cnt wraps, and wraps V_TOT-1→0 when both counters are at terminal count on the same tick.
- Stage 1, registered on each tick, from pre-increment counters:
  - pixel_x ← h_cnt; pixel_y ← v_cnt.
  - pixel_req ← (h_cnt<H_ACTIVE)&&(v_cnt<V_ACTIVE).
  - hs1 ← !(H_ACTIVE+H_FP ≤ h_cnt < H_ACTIVE+H_FP+H_SYNC).
  - vs1 ← !(V_ACTIVE+V_FP ≤ v_cnt < V_ACTIVE+V_FP+V_SYNC).
  - Outside the active area pixel_x/pixel_y still show the counters, but pixel_req=0.
- Upstream contract: pix_r/g/b must hold the colour for the current pixel_x/pixel_y by the next tick, i.e. latency is one pixel tick (two CLOCK_50 cycles). Inputs are sampled only on ticks.
- Stage 2, registered on each tick:
  - VGA_HS ← hs1; VGA_VS ← vs1; VGA_BLANK_N ← pixel_req.
  - VGA_R/G/B ← pixel_req ? pix_* : 0. Colour is forced to zero while blanked, whatever upstream drives.
- Total pin latency is 2 ticks from a counter value to its sync/blank/colour on the pins. HS, VS, BLANK and RGB stay mutually aligned.
- frame_start = 1 for exactly the one CLOCK_50 cycle of the tick on which stage 1 loads h_cnt=0, v_cnt=0 (pixel_x=0, pixel_y=0 appears the following cycle).
- Reset (synchronous, any cycle including mid-frame):
  - Next edge: ce=0, h_cnt=0, v_cnt=0.
  - pixel_x=0, pixel_y=0, pixel_req=0, frame_start=0.
  - hs1/vs1=1, VGA_HS=1, VGA_VS=1, VGA_BLANK_N=0, VGA_R/G/B=0, VGA_CLK=0.
  - After reset deasserts, the first tick is the second CLOCK_50 edge. The frame restarts cleanly with no partial sync pulse.
- VGA_SYNC_N is constant 0, including during reset.
- Boundaries:
  - Last active pixel h=639 has pixel_req=1; h=640 has pixel_req=0.
  - Line 479 is active; line 480 is blank.
  - Simultaneous h and v wrap produces a single frame_start with no extra line.

Test Plan:
- Reset held 5 cycles then released → during reset VGA_HS=VGA_VS=1, VGA_BLANK_N=0, RGB=0, VGA_SYNC_N=0. VGA_CLK toggles with a 40 ns period after release.
- Free run one line → VGA_HS falling edges 1600 CLOCK_50 cycles (32.0 µs) apart, low for 192 cycles (3.84 µs). VGA_BLANK_N high for 1280 cycles per active line.
- Free run two frames → VGA_VS period 840,000 cycles (16.8 ms), low for 2 lines (3200 cycles). frame_start pulses exactly once per frame, 840,000 cycles apart.
- Upstream model returns {pix_r,pix_g,pix_b} = {pixel_x[7:0], pixel_y[7:0], 8'hA5} one tick later → pixel (3,7) appears as R=3, G=7, B=A5 on the same tick BLANK_N is high. RGB is 0 at h=640..799 even with pix_b driven FF.
- Reset asserted at line 200, pixel 300, for 1 cycle → next edge all outputs at reset values. The next frame_start occurs on the first tick after release, and the following VS timing matches scenario 3.
- Override params H_ACTIVE=8, H_FP=2, H_SYNC=3, H_BP=1, V_ACTIVE=4, V_FP=1, V_SYNC=1, V_BP=1 → HS period 28 cycles, low 6. VS period 196 cycles. pixel_req high for 8 ticks on each of lines 0..3.
